// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side byte stream of the UART receive buffer: head byte, valid and ready.
interface uart_rx_ctrl_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver control: bclk divider, enable/resync FSM, FWFT byte FIFO with sticky flags.
// Define UART_RX_CTRL_TIMEOUT_EN to build the bit-time watchdog, RESYNC state and timeout flag.
module uart_rx_ctrl #(
    parameter int unsigned DIV_W         = 16,
    parameter int unsigned FIFO_AW       = 3,
    parameter int unsigned TIMEOUT_TICKS = 192
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [DIV_W-1:0]   divisor,
    output logic               bclk,
    output logic               rx_reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_ready,
    input  logic               rx_busy,
    uart_rx_ctrl_if.master     m_bus,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overrun,
    output logic               timeout,
    input  logic               err_clr,
    output logic [1:0]         state
);

    localparam int unsigned Depth = 1 << FIFO_AW;

    localparam logic [1:0] StOff    = 2'd0;
    localparam logic [1:0] StIdle   = 2'd1;
    localparam logic [1:0] StRecv   = 2'd2;
    localparam logic [1:0] StResync = 2'd3;

    // Baud divider; divisor 0 and 1 both give a tick every cycle.
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_m1;
    logic             bclk_q;

    always_comb begin
        div_m1 = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else if (!enable) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else if (cnt_q >= div_m1) begin
            cnt_q  <= '0;
            bclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
            bclk_q <= 1'b0;
        end
    end

    assign bclk = bclk_q;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       rx_reset_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_TICKS + 1);

    logic [WdW-1:0] wd_q;
    logic           rs_q;
    logic           timeout_q;
    logic           to_set;
`endif

    always_comb begin
        state_d = state_q;
`ifdef UART_RX_CTRL_TIMEOUT_EN
        to_set  = 1'b0;
`endif
        case (state_q)
            StOff: begin
                if (enable) state_d = StIdle;
            end
            StIdle: begin
                if (rx_busy) state_d = StRecv;
            end
            StRecv: begin
                if (!rx_busy) begin
                    state_d = StIdle;
`ifdef UART_RX_CTRL_TIMEOUT_EN
                end else if (wd_q == WdW'(TIMEOUT_TICKS)) begin
                    state_d = StResync;
                    to_set  = 1'b1;
`endif
                end
            end
            StResync: begin
`ifdef UART_RX_CTRL_TIMEOUT_EN
                if (rs_q) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StOff;
        endcase
        if (!enable) begin
            state_d = StOff;
`ifdef UART_RX_CTRL_TIMEOUT_EN
            to_set  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StOff;
            rx_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rx_reset_q <= (state_d == StOff) || (state_d == StResync);
        end
    end

    assign state    = state_q;
    assign rx_reset = rx_reset_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    // Watchdog restarts on each RECV entry and saturates at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            rs_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == StOff) || (state_d == StRecv && state_q != StRecv)) begin
                wd_q <= '0;
            end else if (state_q == StRecv && bclk_q && wd_q != WdW'(TIMEOUT_TICKS)) begin
                wd_q <= wd_q + WdW'(1);
            end
            rs_q <= (state_q == StResync) && !rs_q;
            if (to_set) begin
                timeout_q <= 1'b1;
            end else if (err_clr) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    logic [7:0]         mem [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               overrun_q;
    logic               full;
    logic               pop;
    logic               wr_req;
    logic               push;
    logic               ovr_set;

    always_comb begin
        full    = (count_q == (FIFO_AW + 1)'(Depth));
        pop     = (count_q != '0) && m_bus.m_ready;
        wr_req  = rx_ready && enable && (state_q != StOff) && (state_q != StResync);
        // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
        push    = wr_req && (!full || pop);
        ovr_set = wr_req && full && !pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            if (push && !pop) begin
                count_q <= count_q + (FIFO_AW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (FIFO_AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (ovr_set) begin
            overrun_q <= 1'b1;
        end else if (err_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun       = overrun_q;
    assign fifo_count    = count_q;
    assign m_bus.m_valid = (count_q != '0);
    assign m_bus.m_data  = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (follows UART_RX_CTRL_TIMEOUT_EN when defined).
module tb_uart_rx_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] divisor;
    logic        bclk;
    logic        rx_reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_busy;
    logic [3:0]  fifo_count;
    logic        overrun;
    logic        timeout;
    logic        err_clr;
    logic [1:0]  state;

    int vectors = 0;
    int errors  = 0;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(
        .DIV_W        (16),
        .FIFO_AW      (3),
        .TIMEOUT_TICKS(192)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .divisor   (divisor),
        .bclk      (bclk),
        .rx_reset  (rx_reset),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .m_bus     (bus.master),
        .fifo_count(fifo_count),
        .overrun   (overrun),
        .timeout   (timeout),
        .err_clr   (err_clr),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bclk"},     32'(bclk),         32'd0);
        chk({tag, "_rx_reset"}, 32'(rx_reset),     32'd1);
        chk({tag, "_state"},    32'(state),        32'd0);
        chk({tag, "_m_valid"},  32'(bus.m_valid),  32'd0);
        chk({tag, "_m_data"},   32'(bus.m_data),   32'd0);
        chk({tag, "_count"},    32'(fifo_count),   32'd0);
        chk({tag, "_overrun"},  32'(overrun),      32'd0);
        chk({tag, "_timeout"},  32'(timeout),      32'd0);
    endtask

    initial begin
        int n;
        reset_n     = 1'b0;
        enable      = 1'b1;
        divisor     = 16'd4;
        rx_data     = 8'h00;
        rx_ready    = 1'b0;
        rx_busy     = 1'b0;
        err_clr     = 1'b0;
        bus.m_ready = 1'b0;

        // Reset values, then release with enable=1, divisor=4.
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) begin
                chk("rel_rx_reset", 32'(rx_reset), 32'd0);
                chk("rel_state",    32'(state),    32'd1);
            end
            chk($sformatf("bclk_%0d", i), 32'(bclk), 32'((i % 4) == 0));
        end
        chk("rel_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rel_count",   32'(fifo_count),  32'd0);
        chk("rel_overrun", 32'(overrun),     32'd0);
        chk("rel_timeout", 32'(timeout),     32'd0);

        // Three bytes buffered, then drained in order.
        push(8'h55);
        chk("f1_count", 32'(fifo_count),  32'd1);
        chk("f1_valid", 32'(bus.m_valid), 32'd1);
        chk("f1_data",  32'(bus.m_data),  32'h55);
        push(8'hA3);
        chk("f2_count", 32'(fifo_count),  32'd2);
        push(8'h00);
        chk("f3_count", 32'(fifo_count),  32'd3);
        chk("f3_head",  32'(bus.m_data),  32'h55);
        bus.m_ready = 1'b1;
        chk("pop0_data", 32'(bus.m_data), 32'h55);
        tick();
        chk("pop1_data",  32'(bus.m_data),  32'hA3);
        chk("pop1_count", 32'(fifo_count),  32'd2);
        tick();
        chk("pop2_data",  32'(bus.m_data),  32'h00);
        chk("pop2_valid", 32'(bus.m_valid), 32'd1);
        tick();
        chk("pop3_valid", 32'(bus.m_valid), 32'd0);
        chk("pop3_count", 32'(fifo_count),  32'd0);
        bus.m_ready = 1'b0;

        // Nine bytes into an 8-deep FIFO: the ninth is dropped.
        for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
        chk("ovr_count",   32'(fifo_count), 32'd8);
        chk("ovr_flag",    32'(overrun),    32'd1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ovr_pop%0d", i), 32'(bus.m_data), 32'(8'h10 + i));
            tick();
        end
        bus.m_ready = 1'b0;
        chk("ovr_left", 32'(fifo_count), 32'd3);

        // Enable dropped in RECV with 3 bytes held.
        rx_busy = 1'b1;
        tick();
        chk("dis_recv", 32'(state), 32'd2);
        enable = 1'b0;
        tick();
        chk("dis_state",    32'(state),       32'd0);
        chk("dis_rx_reset", 32'(rx_reset),    32'd1);
        chk("dis_count",    32'(fifo_count),  32'd0);
        chk("dis_valid",    32'(bus.m_valid), 32'd0);
        chk("dis_overrun",  32'(overrun),     32'd1);
        chk("dis_timeout",  32'(timeout),     32'd0);
        rx_busy = 1'b0;
        enable  = 1'b1;
        tick();
        chk("en_state", 32'(state), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_overrun", 32'(overrun), 32'd0);

        // Full FIFO with a pop in the ninth byte's cycle keeps that byte.
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        chk("fp_count8", 32'(fifo_count), 32'd8);
        bus.m_ready = 1'b1;
        push(8'h28);
        bus.m_ready = 1'b0;
        chk("fp_count", 32'(fifo_count), 32'd8);
        chk("fp_ovr",   32'(overrun),    32'd0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fp_pop%0d", i), 32'(bus.m_data), 32'(8'h21 + i));
            tick();
        end
        bus.m_ready = 1'b0;
        chk("fp_empty", 32'(bus.m_valid), 32'd0);

        // Stuck rx_busy with a tick every cycle.
        divisor = 16'd1;
        tick();
        tick();
        rx_busy = 1'b1;
        tick();
        chk("wd_recv", 32'(state), 32'd2);
        n = 0;
        do begin
            tick();
            n++;
        end while (state != 2'd3 && n < 300);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        chk("wd_cycles",   32'(n),        32'd193);
        chk("wd_timeout",  32'(timeout),  32'd1);
        chk("wd_rst1",     32'(rx_reset), 32'd1);
        rx_busy = 1'b0;
        tick();
        chk("wd_state2",   32'(state),    32'd3);
        chk("wd_rst2",     32'(rx_reset), 32'd1);
        tick();
        chk("wd_idle",     32'(state),    32'd1);
        chk("wd_rst_off",  32'(rx_reset), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_clr",      32'(timeout),  32'd0);
`else
        chk("wd_cycles",   32'(n),        32'd300);
        chk("wd_stay",     32'(state),    32'd2);
        chk("wd_timeout",  32'(timeout),  32'd0);
        rx_busy = 1'b0;
        tick();
        chk("wd_idle",     32'(state),    32'd1);
`endif

        // Asynchronous reset mid-frame, between clock edges.
        push(8'h77);
        rx_busy = 1'b1;
        tick();
        chk("ar_recv",  32'(state),       32'd2);
        chk("ar_valid", 32'(bus.m_valid), 32'd1);
        chk("ar_bclk",  32'(bclk),        32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        rx_busy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
